// File: rtl/joint_stepper_gen_if.sv
// Step/direction generator bundle: host-side velocity and enable in,
// step/dir pins and position feedback out.
interface joint_stepper_gen_if #(
  parameter int WIDTH = 32
) ();
  logic             enable;
  logic [WIDTH-1:0] velocity;
  logic             stp;
  logic             dir;
  logic [WIDTH-1:0] position;
  logic             overrun;

  modport master (output enable, velocity, input stp, dir, position, overrun);
  modport slave  (input enable, velocity, output stp, dir, position, overrun);
endinterface

// File: rtl/joint_stepper_gen.sv
// Per-joint step/dir pulse generator: phase accumulator step requests, a pulse
// FSM with fixed high/low times and DIR setup/hold, and a signed step count.
//
// state | meaning
// IDLE  | waiting for a pending step request
// PULSE | stp high for PULSE_LEN cycles
// GAP   | stp low for PULSE_LEN cycles, dir held
// SETUP | dir just changed, waiting DIR_SETUP cycles before the step
module joint_stepper_gen #(
  parameter int WIDTH     = 32,
  parameter int PULSE_LEN = 100,
  parameter int DIR_SETUP = 50,
  parameter int TMR_W     = 16
) (
  input  logic               sysclk,
  input  logic               rst_n,
  joint_stepper_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, SETUP} state_t;

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(DIR_SETUP - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             stp_q, stp_nxt;
  logic             dir_q, dir_nxt;
  logic [WIDTH-1:0] pos_q, pos_nxt;
  logic             overrun_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mag;
  logic [WIDTH:0]   sum;
  logic             pending;
  logic             carry;
  logic             consume;
  logic             req_dir;

  // |velocity|, with the most-negative value saturated so it still fits
  always_comb begin
    mag = bus.velocity;
    if (bus.velocity[WIDTH-1]) begin
      if (bus.velocity == MOST_NEG) mag = MOST_POS;
      else                          mag = -bus.velocity;
    end
  end

  assign req_dir = ~bus.velocity[WIDTH-1];
  assign sum     = {1'b0, acc} + {1'b0, mag};
  assign carry   = bus.enable & sum[WIDTH];

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    stp_nxt   = stp_q;
    dir_nxt   = dir_q;
    pos_nxt   = pos_q;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && pending) begin
          if (req_dir == dir_q) begin
            state_nxt = PULSE;
            stp_nxt   = 1'b1;
            timer_nxt = PULSE_LD;
            consume   = 1'b1;
            pos_nxt   = dir_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
          end else begin
            state_nxt = SETUP;
            dir_nxt   = req_dir;
            timer_nxt = SETUP_LD;
          end
        end
      end
      PULSE: begin
        if (timer == '0) begin
          state_nxt = GAP;
          stp_nxt   = 1'b0;
          timer_nxt = PULSE_LD;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      GAP, SETUP: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - TMR_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        stp_nxt   = 1'b0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      stp_q     <= 1'b0;
      dir_q     <= 1'b1;
      pos_q     <= '0;
      overrun_q <= 1'b0;
      acc       <= '0;
      pending   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      stp_q <= stp_nxt;
      dir_q <= dir_nxt;
      pos_q <= pos_nxt;
      // a carry landing on the cycle IDLE takes the request simply re-arms it
      overrun_q <= overrun_q | (carry & pending & ~consume);
      if (bus.enable) begin
        acc     <= sum[WIDTH-1:0];
        pending <= carry | (pending & ~consume);
      end else begin
        pending <= 1'b0;
      end
    end
  end

  assign bus.stp      = stp_q;
  assign bus.dir      = dir_q;
  assign bus.position = pos_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_joint_stepper_gen.sv
// Bench for joint_stepper_gen: timeline model of step scheduling compared every
// cycle, pulse-shape monitor, and directed literal checks.
module tb_joint_stepper_gen;

  localparam int P = 4;
  localparam int D = 3;

  logic sysclk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  joint_stepper_gen_if #(.WIDTH(32)) bus ();

  joint_stepper_gen #(.WIDTH(32), .PULSE_LEN(P), .DIR_SETUP(D), .TMR_W(16)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  // model: steps are scheduled on a timeline of edge numbers rather than states
  longint      m_acc, m_cyc, m_stp_end, m_ready;
  logic        m_pend, m_dir, m_ovr, m_stp;
  logic [31:0] m_pos;

  always @(posedge sysclk or negedge rst_n) begin
    longint v, mag, s;
    logic   req, carry, take;
    if (!rst_n) begin
      m_acc = 0; m_cyc = 0; m_stp_end = 0; m_ready = 0;
      m_pend = 0; m_dir = 1; m_ovr = 0; m_stp = 0; m_pos = 0;
    end else begin
      m_cyc = m_cyc + 1;
      v   = longint'($signed(bus.velocity));
      mag = (v >= 0) ? v : ((v == -(longint'(1) << 31)) ? (longint'(1) << 31) - 1 : -v);
      req = (v >= 0);
      take = 0;
      if (bus.enable && m_pend && m_cyc >= m_ready) begin
        if (req == m_dir) begin
          take = 1;
          m_stp_end = m_cyc + P;
          m_ready   = m_cyc + 2 * P + 1;
          m_pos     = m_dir ? m_pos + 1 : m_pos - 1;
        end else begin
          m_dir   = req;
          m_ready = m_cyc + D + 1;
        end
      end
      if (bus.enable) begin
        s     = m_acc + mag;
        carry = (s >= (longint'(1) << 32));
        m_acc = s % (longint'(1) << 32);
        if (carry && m_pend && !take) m_ovr = 1;
        m_pend = carry || (m_pend && !take);
      end else begin
        m_pend = 0;
      end
      m_stp = (m_cyc < m_stp_end);
    end
  end

  always @(negedge sysclk) begin
    if (rst_n) begin
      vectors++;
      if (bus.stp !== m_stp || bus.dir !== m_dir || bus.position !== m_pos || bus.overrun !== m_ovr) begin
        miscompares++;
        $display("FAIL cycle%0d stp/dir/pos/ovr act=%b/%b/%0d/%b exp=%b/%b/%0d/%b", cyc,
                 bus.stp, bus.dir, $signed(bus.position), bus.overrun,
                 m_stp, m_dir, $signed(m_pos), m_ovr);
      end
    end
  end

  // pulse shape: high exactly P, low at least P+1 between pulses
  int   rises = 0;
  int   hi_cnt, lo_cnt;
  logic prev_stp, seen_fall;

  always @(negedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stp = 0; seen_fall = 0; hi_cnt = 0; lo_cnt = 0;
    end else if (!sysclk) begin
      if (bus.stp) begin
        if (!prev_stp) begin
          if (seen_fall) begin
            vectors++;
            if (lo_cnt < P + 1) begin
              miscompares++;
              $display("FAIL stp_low_time act=%0d exp>=%0d", lo_cnt, P + 1);
            end
          end
          hi_cnt = 1;
          rises++;
        end else hi_cnt++;
      end else begin
        if (prev_stp) begin
          vectors++;
          if (hi_cnt != P) begin
            miscompares++;
            $display("FAIL stp_high_time act=%0d exp=%0d", hi_cnt, P);
          end
          seen_fall = 1;
          lo_cnt = 1;
        end else lo_cnt++;
      end
      prev_stp = bus.stp;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      #1;
    end
  endtask

  task automatic wait_rise(input int bound, output int at);
    int r0 = rises;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge sysclk);
      #1;
      if (rises != r0) begin
        at = cyc;
        return;
      end
    end
    check("wait_rise_timeout", 0, 1);
  endtask

  initial begin
    int t0, t1, td;
    rst_n = 0;
    bus.enable = 0;
    bus.velocity = 0;

    // 1: reset state
    tick(4);
    check("rst_stp", bus.stp, 0);
    check("rst_dir", bus.dir, 1);
    check("rst_pos", bus.position, 0);
    check("rst_ovr", bus.overrun, 0);
    rst_n = 1;
    tick(6);
    check("idle_stp", bus.stp, 0);

    // 2: steady positive stepping, one pulse per 16 cycles
    bus.enable = 1;
    bus.velocity = 32'h1000_0000;
    wait_rise(40, t0);
    for (int k = 0; k < 9; k++) begin
      wait_rise(40, t1);
      check("period16", t1 - t0, 16);
      t0 = t1;
    end
    check("pos_after10", bus.position, 10);
    check("ovr_t2", bus.overrun, 0);

    // 3: reversal, dir only moves in IDLE and leads stp by SETUP+1
    bus.velocity = -32'sh1000_0000;
    td = -1;
    for (int i = 0; i < 60 && td < 0; i++) begin
      tick(1);
      if (bus.dir == 0) td = cyc;
    end
    check("dir_fell", td >= 0, 1);
    check("stp_at_dir_edge", bus.stp, 0);
    wait_rise(40, t1);
    check("dir_to_stp", t1 - td, 4);
    for (int k = 0; k < 3; k++) wait_rise(40, t1);
    check("pos_down", bus.position, 6);

    // 4: requests faster than the pulse rate
    bus.velocity = 32'h7FFF_FFFF;
    tick(200);
    check("ovr_set", bus.overrun, 1);
    bus.velocity = 0;
    tick(20);
    check("ovr_sticky", bus.overrun, 1);

    // 5: async reset in the middle of a pulse
    bus.velocity = 32'h1000_0000;
    wait_rise(40, t1);
    rst_n = 0;
    #1;
    check("arst_stp", bus.stp, 0);
    check("arst_pos", bus.position, 0);
    check("arst_ovr", bus.overrun, 0);
    check("arst_dir", bus.dir, 1);
    tick(2);
    rst_n = 1;
    t0 = cyc;
    wait_rise(40, t1);
    check("first_rise_after_rst", t1 - t0, 17);
    check("pos_after_rst", bus.position, 1);

    // 6: drop enable mid-pulse, acc held across the pause
    bus.enable = 0;
    t0 = rises;
    tick(40);
    check("no_rise_disabled", rises - t0, 0);
    check("stp_disabled", bus.stp, 0);
    bus.enable = 1;
    t0 = cyc;
    wait_rise(40, t1);
    check("resume_delay", t1 - t0, 16);
    check("pos_resume", bus.position, 2);
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
